// File: rtl/cdb_pkg.sv
// Shared types, default widths and the round-robin pointer helper for the CDB arbiter.
package cdb_pkg;

   localparam int CDB_TAG_W  = 6;
   localparam int CDB_ROB_W  = 6;
   localparam int CDB_DATA_W = 32;

   typedef struct packed {
      logic                  valid;
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_ROB_W-1:0]  rob;
      logic [CDB_DATA_W-1:0] value;
   } cdb_result_t;

   // A negative last index means nothing was granted, so the pointer holds.
   function automatic int rr_next(input int ptr, input int last, input int n);
      if (last < 0) return ptr;
      return (last + 1 >= n) ? 0 : last + 1;
   endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational round-robin picker: scans requests from rr_ptr and hands the
// first pending entries to consecutive ports, optionally leaving port 0 free.
module cdb_rr_picker #(
   parameter int NREQ   = 4,
   parameter int NPORTS = 2,
   parameter int PTR_W  = 2
) (
   input  logic [NREQ-1:0]               req,
   input  logic [PTR_W-1:0]              rr_ptr,
   input  logic                          skip_first,
   output logic [NPORTS-1:0][PTR_W-1:0]  grant_idx,
   output logic [NPORTS-1:0]             grant_vld,
   output logic [NREQ-1:0]               grant_mask,
   output logic                          any_grant,
   output logic [PTR_W-1:0]              last_idx
);

   localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PORT_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

   always_comb begin
      int port;
      int idx;
      grant_idx  = '0;
      grant_vld  = '0;
      grant_mask = '0;
      any_grant  = 1'b0;
      last_idx   = '0;
      idx        = 0;
      port       = skip_first ? 1 : 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[IDX_W'(idx)] && (port < NPORTS)) begin
            grant_idx[PORT_W'(port)] = PTR_W'(idx);
            grant_vld[PORT_W'(port)] = 1'b1;
            grant_mask[IDX_W'(idx)]  = 1'b1;
            any_grant                = 1'b1;
            last_idx                 = PTR_W'(idx);
            port                     = port + 1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Result-bus arbiter: one holding buffer per producer, NUM_PORTS registered broadcast buses.
// Optional CDB_LSQ_PRIORITY_EN gives the LSQ (index NUM_REQ-1) fixed priority on port 0.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int NUM_PORTS = 2,
   parameter int TAG_W     = CDB_TAG_W,
   parameter int ROB_W     = CDB_ROB_W,
   parameter int DATA_W    = CDB_DATA_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          in_valid,
   output logic [NUM_REQ-1:0]          in_ready,
   input  logic [NUM_REQ*TAG_W-1:0]    in_tag,
   input  logic [NUM_REQ*ROB_W-1:0]    in_rob,
   input  logic [NUM_REQ*DATA_W-1:0]   in_value,
   output logic [NUM_PORTS-1:0]        out_valid,
   output logic [NUM_PORTS*TAG_W-1:0]  out_tag,
   output logic [NUM_PORTS*ROB_W-1:0]  out_rob,
   output logic [NUM_PORTS*DATA_W-1:0] out_value
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef CDB_LSQ_PRIORITY_EN
   localparam int RR_N = NUM_REQ - 1;
`else
   localparam int RR_N = NUM_REQ;
`endif

   logic [NUM_REQ-1:0]  pend_q, pend_d;
   logic [TAG_W-1:0]    buf_tag_q   [NUM_REQ];
   logic [TAG_W-1:0]    buf_tag_d   [NUM_REQ];
   logic [ROB_W-1:0]    buf_rob_q   [NUM_REQ];
   logic [ROB_W-1:0]    buf_rob_d   [NUM_REQ];
   logic [DATA_W-1:0]   buf_value_q [NUM_REQ];
   logic [DATA_W-1:0]   buf_value_d [NUM_REQ];
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;

   logic [NUM_PORTS-1:0] out_valid_q, out_valid_d;
   logic [TAG_W-1:0]     out_tag_q   [NUM_PORTS];
   logic [TAG_W-1:0]     out_tag_d   [NUM_PORTS];
   logic [ROB_W-1:0]     out_rob_q   [NUM_PORTS];
   logic [ROB_W-1:0]     out_rob_d   [NUM_PORTS];
   logic [DATA_W-1:0]    out_value_q [NUM_PORTS];
   logic [DATA_W-1:0]    out_value_d [NUM_PORTS];

   logic [RR_N-1:0]                  rr_req, rr_mask;
   logic                             lsq_first;
   logic [NUM_PORTS-1:0][PTR_W-1:0]  pk_idx;
   logic [NUM_PORTS-1:0]             pk_vld;
   logic                             pk_any;
   logic [PTR_W-1:0]                 pk_last;

   logic [NUM_REQ-1:0]   grant, accept;
   logic [PTR_W-1:0]     port_src [NUM_PORTS];
   logic [NUM_PORTS-1:0] port_vld;

   // With LSQ priority the round-robin only sees producers 0..NUM_REQ-2.
   always_comb begin
`ifdef CDB_LSQ_PRIORITY_EN
      rr_req    = pend_q[NUM_REQ-2:0];
      lsq_first = pend_q[NUM_REQ-1];
      grant     = {pend_q[NUM_REQ-1], rr_mask};
`else
      rr_req    = pend_q;
      lsq_first = 1'b0;
      grant     = rr_mask;
`endif
   end

   cdb_rr_picker #(
      .NREQ   (RR_N),
      .NPORTS (NUM_PORTS),
      .PTR_W  (PTR_W)
   ) u_picker (
      .req        (rr_req),
      .rr_ptr     (rr_ptr_q),
      .skip_first (lsq_first),
      .grant_idx  (pk_idx),
      .grant_vld  (pk_vld),
      .grant_mask (rr_mask),
      .any_grant  (pk_any),
      .last_idx   (pk_last)
   );

   assign in_ready = ~pend_q | grant;
   assign accept   = in_valid & in_ready;

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         port_vld[p] = pk_vld[p];
         port_src[p] = pk_idx[p];
      end
      if (lsq_first) begin
         port_vld[0] = 1'b1;
         port_src[0] = PTR_W'(NUM_REQ - 1);
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         out_valid_d[p] = port_vld[p];
         out_tag_d[p]   = '0;
         out_rob_d[p]   = '0;
         out_value_d[p] = '0;
         if (port_vld[p]) begin
            out_tag_d[p]   = buf_tag_q[port_src[p]];
            out_rob_d[p]   = buf_rob_q[port_src[p]];
            out_value_d[p] = buf_value_q[port_src[p]];
         end
      end
   end

   // A refill arriving on the cycle the entry is granted keeps it pending.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         pend_d[i]      = pend_q[i];
         buf_tag_d[i]   = buf_tag_q[i];
         buf_rob_d[i]   = buf_rob_q[i];
         buf_value_d[i] = buf_value_q[i];
         if (grant[i]) pend_d[i] = 1'b0;
         if (accept[i]) begin
            pend_d[i]      = 1'b1;
            buf_tag_d[i]   = in_tag[i*TAG_W +: TAG_W];
            buf_rob_d[i]   = in_rob[i*ROB_W +: ROB_W];
            buf_value_d[i] = in_value[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rr_ptr_d = PTR_W'(rr_next(int'(rr_ptr_q), pk_any ? int'(pk_last) : -1, RR_N));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q      <= '0;
         rr_ptr_q    <= '0;
         out_valid_q <= '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            out_tag_q[p]   <= '0;
            out_rob_q[p]   <= '0;
            out_value_q[p] <= '0;
         end
      end else begin
         pend_q      <= pend_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         for (int p = 0; p < NUM_PORTS; p++) begin
            out_tag_q[p]   <= out_tag_d[p];
            out_rob_q[p]   <= out_rob_d[p];
            out_value_q[p] <= out_value_d[p];
         end
      end
   end

   // Buffer contents are qualified by pend_q, so they need no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         buf_tag_q[i]   <= buf_tag_d[i];
         buf_rob_q[i]   <= buf_rob_d[i];
         buf_value_q[i] <= buf_value_d[i];
      end
   end

   always_comb begin
      out_valid = out_valid_q;
      out_tag   = '0;
      out_rob   = '0;
      out_value = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         out_tag[p*TAG_W +: TAG_W]      = out_tag_q[p];
         out_rob[p*ROB_W +: ROB_W]      = out_rob_q[p];
         out_value[p*DATA_W +: DATA_W]  = out_value_q[p];
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a cycle-level model of the arbitration rules.
module tb_cdb_arbiter;
   import cdb_pkg::*;

   localparam int NR = 4;
   localparam int NP = 2;
   localparam int TW = CDB_TAG_W;
   localparam int RW = CDB_ROB_W;
   localparam int DW = CDB_DATA_W;
`ifdef CDB_LSQ_PRIORITY_EN
   localparam int RRN = NR - 1;
`else
   localparam int RRN = NR;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     in_valid, in_ready;
   logic [NR*TW-1:0]  in_tag;
   logic [NR*RW-1:0]  in_rob;
   logic [NR*DW-1:0]  in_value;
   logic [NP-1:0]     out_valid;
   logic [NP*TW-1:0]  out_tag;
   logic [NP*RW-1:0]  out_rob;
   logic [NP*DW-1:0]  out_value;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .TAG_W(TW), .ROB_W(RW), .DATA_W(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_tag    (in_tag),
      .in_rob    (in_rob),
      .in_value  (in_value),
      .out_valid (out_valid),
      .out_tag   (out_tag),
      .out_rob   (out_rob),
      .out_value (out_value)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_acc    = 0;
   int n_bcast  = 0;

   task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: pending buffers, rotating priority pointer, registered broadcasts.
   bit          m_pend [NR];
   logic [TW-1:0] m_tag [NR];
   logic [RW-1:0] m_rob [NR];
   logic [DW-1:0] m_val [NR];
   int          m_rr;
   cdb_result_t m_out [NP];

   // Producer side: an item is held on the bus until accepted.
   bit          p_vld [NR];
   logic [TW-1:0] p_tag [NR];
   logic [RW-1:0] p_rob [NR];
   logic [DW-1:0] p_val [NR];
   int          go_pct [NR];

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_pend[i] = 0;
         p_vld[i]  = 0;
      end
      for (int p = 0; p < NP; p++) m_out[p] = '0;
      m_rr = 0;
   endtask

   task automatic model_grants(output int src[NP], output int new_rr);
      int port;
      int last;
      for (int p = 0; p < NP; p++) src[p] = -1;
      port = 0;
      last = -1;
`ifdef CDB_LSQ_PRIORITY_EN
      if (m_pend[NR-1]) begin
         src[0] = NR - 1;
         port   = 1;
      end
`endif
      for (int k = 0; k < RRN; k++) begin
         int i;
         i = (m_rr + k) % RRN;
         if (m_pend[i] && port < NP) begin
            src[port] = i;
            port++;
            last = i;
         end
      end
      new_rr = (last < 0) ? m_rr : (last + 1) % RRN;
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         in_valid[i]          = p_vld[i];
         in_tag[i*TW +: TW]   = p_tag[i];
         in_rob[i*RW +: RW]   = p_rob[i];
         in_value[i*DW +: DW] = p_val[i];
      end
   endtask

   task automatic set_item(input int i, input logic [TW-1:0] t, input logic [RW-1:0] r, input logic [DW-1:0] v);
      p_vld[i] = 1;
      p_tag[i] = t;
      p_rob[i] = r;
      p_val[i] = v;
   endtask

   // One cycle: check DUT against model at negedge, drive producers, advance model over the next edge.
   task automatic run_cycle();
      int src[NP];
      int new_rr;
      bit gr[NR];
      logic [NR-1:0] exp_rdy;
      logic [NP-1:0] ev;
      logic [NP*TW-1:0] et;
      logic [NP*RW-1:0] er;
      logic [NP*DW-1:0] evl;
      @(negedge clk);
      model_grants(src, new_rr);
      for (int i = 0; i < NR; i++) begin
         gr[i] = 0;
         for (int p = 0; p < NP; p++) if (src[p] == i) gr[i] = 1;
         exp_rdy[i] = !m_pend[i] || gr[i];
      end
      for (int p = 0; p < NP; p++) begin
         ev[p]             = m_out[p].valid;
         et[p*TW +: TW]    = m_out[p].tag;
         er[p*RW +: RW]    = m_out[p].rob;
         evl[p*DW +: DW]   = m_out[p].value;
      end
      check_val("out_valid", 64'(out_valid), 64'(ev));
      check_val("out_tag", 64'(out_tag), 64'(et));
      check_val("out_rob", 64'(out_rob), 64'(er));
      check_val("out_value", 64'(out_value), 64'(evl));
      check_val("in_ready", 64'(in_ready), 64'(exp_rdy));
      n_bcast += $countones(out_valid);
      for (int i = 0; i < NR; i++)
         if (!p_vld[i] && ($urandom_range(99) < go_pct[i]))
            set_item(i, TW'($urandom_range(63)), RW'($urandom_range(63)), $urandom);
      drive();
      for (int p = 0; p < NP; p++) begin
         m_out[p] = '0;
         if (src[p] >= 0) begin
            m_out[p].valid = 1'b1;
            m_out[p].tag   = m_tag[src[p]];
            m_out[p].rob   = m_rob[src[p]];
            m_out[p].value = m_val[src[p]];
         end
      end
      for (int i = 0; i < NR; i++) begin
         if (p_vld[i] && exp_rdy[i]) begin
            m_pend[i] = 1;
            m_tag[i]  = p_tag[i];
            m_rob[i]  = p_rob[i];
            m_val[i]  = p_val[i];
            p_vld[i]  = 0;
            n_acc++;
         end else if (gr[i]) begin
            m_pend[i] = 0;
         end
      end
      m_rr = new_rr;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      drive();
      n_acc   = 0;
      n_bcast = 0;
      check_val("reset_out_valid", 64'(out_valid), 64'd0);
      check_val("reset_out_fields", 64'(out_tag | out_rob | out_value[NP*DW-1:0]), 64'd0);
      check_val("reset_in_ready", 64'(in_ready), 64'hF);
   endtask

   task automatic set_pct(input int a, input int b, input int c, input int d);
      go_pct[0] = a;
      go_pct[1] = b;
      go_pct[2] = c;
      go_pct[3] = d;
   endtask

   initial begin
      logic [NP*TW-1:0] exp_tags;
      in_tag   = '0;
      in_rob   = '0;
      in_value = '0;
      set_pct(0, 0, 0, 0);
      do_reset();

      // Single result from producer 0.
      set_item(0, 6'd5, 6'd3, 32'hDEADBEEF);
      repeat (3) run_cycle();
      check_val("single_valid", 64'(out_valid), 64'b01);
      check_val("single_tag", 64'(out_tag[TW-1:0]), 64'd5);
      check_val("single_rob", 64'(out_rob[RW-1:0]), 64'd3);
      check_val("single_value", 64'(out_value[DW-1:0]), 64'hDEADBEEF);
      check_val("single_ready0", 64'(in_ready[0]), 64'd1);
      repeat (3) run_cycle();

      // Four simultaneous results with tags 1..4.
      do_reset();
      for (int i = 0; i < NR; i++) set_item(i, TW'(i + 1), RW'(i), DW'(100 + i));
      repeat (3) run_cycle();
`ifdef CDB_LSQ_PRIORITY_EN
      exp_tags = {6'd1, 6'd4};
`else
      exp_tags = {6'd2, 6'd1};
`endif
      check_val("four_c2_tags", 64'(out_tag), 64'(exp_tags));
      run_cycle();
`ifdef CDB_LSQ_PRIORITY_EN
      exp_tags = {6'd3, 6'd2};
`else
      exp_tags = {6'd4, 6'd3};
`endif
      check_val("four_c3_tags", 64'(out_tag), 64'(exp_tags));
      repeat (3) run_cycle();

      // Refill-on-grant: producer 1 streams values 1,2,3...
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (!p_vld[1]) set_item(1, TW'(c + 1), RW'(c), DW'(c + 1));
         run_cycle();
         if (c >= 2) begin
            check_val("refill_value", 64'(out_value[DW-1:0]), 64'(c - 1));
            check_val("refill_valid", 64'(out_valid), 64'b01);
         end
      end
      repeat (4) run_cycle();

      // Full backpressure, then randomized load with a mid-traffic reset.
      do_reset();
      set_pct(100, 100, 100, 100);
      repeat (200) run_cycle();
      for (int ph = 0; ph < 6; ph++) begin
         set_pct($urandom_range(100), $urandom_range(100), $urandom_range(100), $urandom_range(100));
         repeat (250) run_cycle();
         if (ph == 2) do_reset();
      end
      set_pct(0, 0, 0, 0);
      for (int i = 0; i < NR; i++) p_vld[i] = p_vld[i];
      repeat (12) run_cycle();
      check_val("conservation", 64'(n_bcast), 64'(n_acc));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
